cluster_event_wait_unit: RTL and testbench
==========================================

// Module: cluster_event_wait_unit
// PURPOSE
// - Per-core consumer of the 32-bit mapped event vector produced by the cluster event map.
// - Captures event pulses into a sticky buffer and filters them with a software mask.
// - Runs the core wait/sleep handshake: gates the core clock until a masked event is pending, then returns the event ID.
// - One instance per core, between the event map and the core's clock gate / wake-up port.
// PARAMETERS
// - NB_EVENTS  32  width of event vector/buffer/mask; power of 2, 2..32
// - EVT_ID_W   $clog2(NB_EVENTS)  width of returned event IDs (derived, not overridden)
// PORTS
// - clk_i             in   1          cluster clock
// - rst_i             in   1          asynchronous reset, active-high
// - events_i          in   NB_EVENTS  single-cycle event pulses from event map
// - mask_we_i         in   1          write strobe for event mask
// - mask_wdata_i      in   NB_EVENTS  new event mask value
// - mask_o            out  NB_EVENTS  current event mask
// - buffer_clr_i      in   NB_EVENTS  write-1-to-clear strobe for buffer bits (one cycle)
// - buffer_o          out  NB_EVENTS  sticky event buffer
// - wait_req_i        in   1          core wait request; held high until wait_ack_o
// - wait_clr_i        in   1          sampled with wait_req_i rise: clear returned event on ack
// - wait_ack_o        out  1          one-cycle wait completion pulse
// - wait_id_o         out  EVT_ID_W   event ID returned with wait_ack_o
// - core_clk_en_o     out  1          core clock-gate enable (0 = core sleeping)
// - overflow_o        out  1          sticky: event pulse hit an already-set buffer bit
// - overflow_clr_i    in   1          clears overflow_o
// - irq_*             see CONFIGURATION
// BEHAVIOUR
// - Reset: buffer=0, mask=0, overflow_o=0, wait_ack_o=0, wait_id_o=0, core_clk_en_o=1, FSM=ACTIVE.
// - Buffer bit i next = (buffer[i] & ~buffer_clr_i[i] & ~ack_clr[i]) | events_i[i]; set wins over any clear in the same cycle.
// - overflow_o sets when events_i[i] & buffer[i] for any i, clear term ignored; a set in the same cycle as overflow_clr_i wins.
// - mask_we_i updates mask next cycle; new mask used by FSM from that next cycle.
// - pending = (buffer | events_i) & mask (combinational; same-cycle events count).
// - sel_id = lowest-index set bit of pending.
// - FSM ACTIVE: core_clk_en_o=1.
//   - If wait_req_i & pending!=0: go ACK.
//   - If wait_req_i & pending==0: go SLEEP.
//   - In both cases latch wait_clr_i.
// - FSM SLEEP: core_clk_en_o=0; stays until pending!=0, then go WAKE (registered, 1 cycle).
// - FSM WAKE: core_clk_en_o=1; always go ACK next cycle (gives core one clock before ack).
// - FSM ACK:
//   - wait_ack_o=1 for exactly one cycle; wait_id_o=sel_id of that cycle, held until the next ack.
//   - If latched clr: clear buffer[sel_id] at the clock edge ending ACK, unless the same bit gets a new pulse that cycle.
//   - Go ACTIVE next cycle.
// - Latencies: pending already present -> ack 1 cycle after req. Event during sleep -> clk_en high 1 cycle after event, ack 2 cycles after event.
// - Mask cleared while in SLEEP: remains asleep (no spurious wake).
// - wait_req_i deassert before ack is a protocol violation; FSM completes the sequence regardless.
// - Async reset in any state returns to ACTIVE with core_clk_en_o=1 in the same cycle; pending wait is dropped.
// CONFIGURATION
// - Macro CLUSTER_EVENT_IRQ_EN.
// - Defined, added ports:
//   - irq_mask_we_i (in 1), irq_mask_wdata_i (in NB_EVENTS), irq_mask_o (out NB_EVENTS)
//   - irq_req_o (out 1), irq_id_o (out EVT_ID_W), irq_ack_i (in 1)
// - Defined, behaviour:
//   - irq_req_o is registered: 1 while (buffer & irq_mask)!=0; irq_id_o = lowest set index, registered.
//   - irq_ack_i clears buffer[irq_id_o] (same set-wins rule).
//   - A pending irq also wakes SLEEP (go WAKE) but does not produce wait_ack until a wait-masked event exists.
// - Undefined: irq ports absent, no irq mask register, wake only via mask.
// TESTING
// - Reset then idle: core_clk_en_o=1, buffer_o=0, mask_o=0, wait_ack_o never asserts.
// - mask=0x0000_0100, buffer bit 8 set, wait_req+clr -> ack next cycle, wait_id=8, buffer bit 8 cleared, clk_en stays 1.
// - mask=0x0001_0000, wait_req, no events -> clk_en=0; pulse event 16 at cycle T -> clk_en=1 at T+1, ack at T+2, id=16.
// - Pulse events 3 and 9 together, mask=0x208, wait+clr -> id=3, buffer keeps bit 9; second wait -> id=9 immediately.
// - Event 5 pulse in same cycle as buffer_clr_i[5] with bit already set -> bit stays 1, overflow_o=1; overflow_clr_i -> 0.
// - Assert rst_i while in SLEEP -> clk_en=1 immediately, FSM ACTIVE, no ack.
// - CLUSTER_EVENT_IRQ_EN on: irq_mask=0x400, pulse event 10 -> irq_req=1, id=10; irq_ack -> irq_req=0 next cycle.

Source files
------------

// File: rtl/cluster_event_wait_unit.sv
// rtl/cluster_event_wait_unit.sv - per-core event buffer, mask and wait/sleep handshake
//
// Purpose:
//   Consumes the mapped event vector for one core. Event pulses are captured
//   in a sticky buffer, filtered by a software mask, and a wait request from
//   the core either completes at once (masked event pending) or puts the core
//   to sleep by dropping its clock-gate enable until a masked event arrives.
//
// Ports:
//   clk_i, rst_i        cluster clock, asynchronous active-high reset
//   events_i            single-cycle event pulses
//   mask_we_i/wdata_i   event mask write; mask_o shows the current mask
//   buffer_clr_i        write-1-to-clear strobe for buffer bits
//   buffer_o            sticky event buffer
//   wait_req_i          core wait request, held until wait_ack_o
//   wait_clr_i          sampled with the request: clear returned event on ack
//   wait_ack_o          one-cycle completion pulse; wait_id_o carries the ID
//   core_clk_en_o       core clock-gate enable (0 = core sleeping)
//   overflow_o          sticky pulse-on-set-bit flag; overflow_clr_i clears it
//
// Optional feature (macro CLUSTER_EVENT_IRQ_EN):
//   irq_mask_we_i/irq_mask_wdata_i/irq_mask_o  interrupt mask register
//   irq_req_o/irq_id_o  registered interrupt request and lowest pending ID
//   irq_ack_i           clears buffer[irq_id_o]
//   A pending interrupt also wakes a sleeping core.

module cluster_event_wait_unit #(
    parameter int NB_EVENTS = 32,
    localparam int EVT_ID_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NB_EVENTS-1:0] events_i,
    input  logic                 mask_we_i,
    input  logic [NB_EVENTS-1:0] mask_wdata_i,
    output logic [NB_EVENTS-1:0] mask_o,
    input  logic [NB_EVENTS-1:0] buffer_clr_i,
    output logic [NB_EVENTS-1:0] buffer_o,
    input  logic                 wait_req_i,
    input  logic                 wait_clr_i,
    output logic                 wait_ack_o,
    output logic [EVT_ID_W-1:0]  wait_id_o,
    output logic                 core_clk_en_o,
    output logic                 overflow_o,
`ifdef CLUSTER_EVENT_IRQ_EN
    input  logic                 irq_mask_we_i,
    input  logic [NB_EVENTS-1:0] irq_mask_wdata_i,
    output logic [NB_EVENTS-1:0] irq_mask_o,
    output logic                 irq_req_o,
    output logic [EVT_ID_W-1:0]  irq_id_o,
    input  logic                 irq_ack_i,
`endif
    input  logic                 overflow_clr_i
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NB_EVENTS-1:0]  buffer_q, buffer_d;
    logic [NB_EVENTS-1:0]  mask_q;
    logic [NB_EVENTS-1:0]  pending;
    logic [NB_EVENTS-1:0]  ack_clr_vec;
    logic [NB_EVENTS-1:0]  irq_clr_vec;
    logic                  pending_any;
    logic                  wake_req;
    logic [EVT_ID_W-1:0]   sel_id;
    logic [EVT_ID_W-1:0]   wait_id_q;
    logic                  clr_q;
    logic                  overflow_q, overflow_d;

    // Same-cycle pulses count as pending so a wait issued together with the
    // event completes without a sleep round trip.
    assign pending     = (buffer_q | events_i) & mask_q;
    assign pending_any = |pending;

    // Lowest-index pending event; scanning downwards lets the lowest win.
    always_comb begin
        sel_id = '0;
        for (int i = NB_EVENTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = EVT_ID_W'(i);
            end
        end
    end

    // Clear-on-ack only applies when something was actually returned.
    always_comb begin
        ack_clr_vec = '0;
        if ((state_q == ST_ACK) && clr_q && pending_any) begin
            ack_clr_vec[sel_id] = 1'b1;
        end
    end

    // New pulses win over every clear source in the same cycle.
    assign buffer_d   = (buffer_q & ~buffer_clr_i & ~ack_clr_vec & ~irq_clr_vec) | events_i;
    assign overflow_d = (|(events_i & buffer_q)) | (overflow_q & ~overflow_clr_i);

`ifdef CLUSTER_EVENT_IRQ_EN
    logic [NB_EVENTS-1:0] irq_mask_q;
    logic [NB_EVENTS-1:0] irq_pending;
    logic                 irq_req_q;
    logic [EVT_ID_W-1:0]  irq_id_q;
    logic [EVT_ID_W-1:0]  irq_sel;

    // Computed from the next buffer value so the request drops on the cycle
    // right after the acknowledging clear.
    assign irq_pending = buffer_d & irq_mask_q;

    always_comb begin
        irq_sel = '0;
        for (int i = NB_EVENTS - 1; i >= 0; i--) begin
            if (irq_pending[i]) begin
                irq_sel = EVT_ID_W'(i);
            end
        end
    end

    always_comb begin
        irq_clr_vec = '0;
        if (irq_ack_i) begin
            irq_clr_vec[irq_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_mask_q <= '0;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            if (irq_mask_we_i) begin
                irq_mask_q <= irq_mask_wdata_i;
            end
            irq_req_q <= |irq_pending;
            irq_id_q  <= irq_sel;
        end
    end

    assign wake_req   = pending_any | irq_req_q;
    assign irq_mask_o = irq_mask_q;
    assign irq_req_o  = irq_req_q;
    assign irq_id_o   = irq_id_q;
`else
    assign irq_clr_vec = '0;
    assign wake_req    = pending_any;
`endif

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buffer_q   <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
            clr_q      <= 1'b0;
            wait_id_q  <= '0;
        end else begin
            buffer_q   <= buffer_d;
            overflow_q <= overflow_d;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
            if ((state_q == ST_ACTIVE) && wait_req_i) begin
                clr_q <= wait_clr_i;
            end
            // Hold the returned ID until the next acknowledge.
            if (state_q == ST_ACK) begin
                wait_id_q <= sel_id;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (wait_req_i) begin
                    state_d = pending_any ? ST_ACK : ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (wake_req) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
`ifdef CLUSTER_EVENT_IRQ_EN
                // An interrupt-only wake keeps the clock running while the
                // interrupt is serviced, and sleeps again once it is gone.
                if (pending_any) begin
                    state_d = ST_ACK;
                end else if (!irq_req_q) begin
                    state_d = ST_SLEEP;
                end
`else
                state_d = ST_ACK;
`endif
            end
            ST_ACK: begin
                state_d = ST_ACTIVE;
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        wait_ack_o    = (state_q == ST_ACK);
        core_clk_en_o = (state_q != ST_SLEEP);
        wait_id_o     = (state_q == ST_ACK) ? sel_id : wait_id_q;
    end

    assign buffer_o   = buffer_q;
    assign mask_o     = mask_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cluster_event_wait_unit.sv
// tb/tb_cluster_event_wait_unit.sv - randomized self-checking bench for cluster_event_wait_unit

module tb_cluster_event_wait_unit;

    logic        clk;
    logic        rst;
    logic [31:0] events;
    logic        mask_we;
    logic [31:0] mask_wdata;
    logic [31:0] mask;
    logic [31:0] buffer_clr;
    logic [31:0] buffer;
    logic        wait_req;
    logic        wait_clr;
    logic        wait_ack;
    logic [4:0]  wait_id;
    logic        core_clk_en;
    logic        overflow;
    logic        overflow_clr;

    cluster_event_wait_unit #(.NB_EVENTS(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .events_i       (events),
        .mask_we_i      (mask_we),
        .mask_wdata_i   (mask_wdata),
        .mask_o         (mask),
        .buffer_clr_i   (buffer_clr),
        .buffer_o       (buffer),
        .wait_req_i     (wait_req),
        .wait_clr_i     (wait_clr),
        .wait_ack_o     (wait_ack),
        .wait_id_o      (wait_id),
        .core_clk_en_o  (core_clk_en),
        .overflow_o     (overflow),
        .overflow_clr_i (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: buffer/mask/overflow as plain vectors, the wait
    // handshake as a schedule (busy flag, sleep flag, cycle of the ack).
    logic [31:0] m_buf;
    logic [31:0] m_mask;
    logic        m_ovf;
    logic        m_busy;
    logic        m_sleep;
    logic        m_clr;
    int          m_ack_cyc;
    int          m_last_id;
    int          cyc;

    // Samples from the most recent step, for literal checks.
    logic        s_ack;
    logic        s_clk;
    logic [31:0] s_id;
    logic [31:0] s_buf;
    logic [31:0] s_mask;
    logic        s_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_buf     = '0;
        m_mask    = '0;
        m_ovf     = 1'b0;
        m_busy    = 1'b0;
        m_sleep   = 1'b0;
        m_clr     = 1'b0;
        m_ack_cyc = -1;
        m_last_id = 0;
    endtask

    task automatic step(input logic [31:0] ev, input logic mwe, input logic [31:0] mwd,
                        input logic [31:0] bclr, input logic req, input logic wclr,
                        input logic oclr);
        logic [31:0] pend;
        logic [31:0] ackclr;
        logic        e_ack;
        int          e_id;
        @(negedge clk);
        events       = ev;
        mask_we      = mwe;
        mask_wdata   = mwd;
        buffer_clr   = bclr;
        wait_req     = req;
        wait_clr     = wclr;
        overflow_clr = oclr;
        #1;
        s_ack  = wait_ack;
        s_clk  = core_clk_en;
        s_id   = 32'(wait_id);
        s_buf  = buffer;
        s_mask = mask;
        s_ovf  = overflow;

        pend  = (m_buf | ev) & m_mask;
        e_ack = (cyc == m_ack_cyc);
        e_id  = e_ack ? lowest(pend) : m_last_id;
        check("clk_en",   32'(s_clk), 32'(!m_sleep));
        check("wait_ack", 32'(s_ack), 32'(e_ack));
        check("wait_id",  s_id, 32'(e_id));
        check("buffer",   s_buf, m_buf);
        check("mask",     s_mask, m_mask);
        check("overflow", 32'(s_ovf), 32'(m_ovf));

        ackclr = '0;
        if (e_ack && m_clr && (pend != 0)) ackclr = 32'd1 << lowest(pend);
        m_ovf = (|(ev & m_buf)) | (m_ovf & ~oclr);
        m_buf = (m_buf & ~bclr & ~ackclr) | ev;
        if (e_ack) begin
            m_last_id = e_id;
            m_busy    = 1'b0;
            m_ack_cyc = -1;
        end else if (!m_busy && req) begin
            m_busy = 1'b1;
            m_clr  = wclr;
            if (pend != 0) m_ack_cyc = cyc + 1;
            else           m_sleep   = 1'b1;
        end else if (m_sleep && (pend != 0)) begin
            m_sleep   = 1'b0;
            m_ack_cyc = cyc + 2;
        end
        if (mwe) m_mask = mwd;
        cyc++;
    endtask

    task automatic idle(input logic req);
        step(32'd0, 1'b0, 32'd0, 32'd0, req, 1'b0, 1'b0);
    endtask

    initial begin
        logic        r_req;
        logic [31:0] r_ev;
        logic [31:0] r_mwd;
        logic [31:0] r_bclr;
        logic        r_mwe;
        cyc          = 0;
        rst          = 1'b1;
        events       = '0;
        mask_we      = 1'b0;
        mask_wdata   = '0;
        buffer_clr   = '0;
        wait_req     = 1'b0;
        wait_clr     = 1'b0;
        overflow_clr = 1'b0;
        model_reset();

        #1;
        check("rst_clk_en", 32'(core_clk_en), 32'd1);
        check("rst_ack",    32'(wait_ack), 32'd0);
        check("rst_id",     32'(wait_id), 32'd0);
        check("rst_buffer", buffer, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (4) idle(1'b0);
        check("idle_clk_en", 32'(s_clk), 32'd1);
        check("idle_mask",   s_mask, 32'd0);

        // Pending event 8 with clear: ack next cycle, id 8, bit cleared
        step(32'd0, 1'b1, 32'h0000_0100, 32'd0, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0100, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("e8_no_ack_yet", 32'(s_ack), 32'd0);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("e8_ack", 32'(s_ack), 32'd1);
        check("e8_id",  s_id, 32'd8);
        idle(1'b0);
        check("e8_cleared", s_buf & 32'h0000_0100, 32'd0);
        check("e8_clk_en",  32'(s_clk), 32'd1);
        check("e8_id_held", s_id, 32'd8);

        // Sleep then wake on event 16
        step(32'd0, 1'b1, 32'h0001_0000, 32'd0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("sleep_clk_en", 32'(s_clk), 32'd0);
        step(32'h0001_0000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("t_clk_en", 32'(s_clk), 32'd0);
        idle(1'b1);
        check("t1_clk_en", 32'(s_clk), 32'd1);
        check("t1_ack",    32'(s_ack), 32'd0);
        idle(1'b1);
        check("t2_ack", 32'(s_ack), 32'd1);
        check("t2_id",  s_id, 32'd16);
        step(32'd0, 1'b0, 32'd0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

        // Events 3 and 9 together: lowest first, 9 kept, then 9 immediately
        step(32'h0000_0208, 1'b1, 32'h0000_0208, 32'd0, 1'b0, 1'b0, 1'b0);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("e3_id", s_id, 32'd3);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("e9_kept", s_buf & 32'h0000_0208, 32'h0000_0200);
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("e9_ack", 32'(s_ack), 32'd1);
        check("e9_id",  s_id, 32'd9);
        idle(1'b0);

        // Overflow: pulse on set bit wins over clear, then overflow clear
        step(32'h0000_0020, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0020, 1'b0, 32'd0, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("e5_kept",  s_buf & 32'h0000_0020, 32'h0000_0020);
        check("ovf_set",  32'(s_ovf), 32'd1);
        step(32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("ovf_clr", 32'(s_ovf), 32'd0);

        // Asynchronous reset while asleep
        step(32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("pre_rst_sleep", 32'(s_clk), 32'd0);
        @(negedge clk);
        wait_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_sleep_clk_en", 32'(core_clk_en), 32'd1);
        check("rst_sleep_ack",    32'(wait_ack), 32'd0);
        check("rst_sleep_mask",   mask, 32'd0);
        model_reset();
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        repeat (3) idle(1'b0);
        check("post_rst_ack", 32'(s_ack), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            r_req  = m_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
            r_ev   = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            if ($urandom_range(0, 7) == 0) r_ev = r_ev | (32'd1 << $urandom_range(0, 31));
            r_mwe  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       r_mwd = 32'd0;
                1:       r_mwd = 32'd1 << $urandom_range(0, 31);
                default: r_mwd = $urandom & $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       r_bclr = 32'hFFFF_FFFF;
                1:       r_bclr = $urandom;
                default: r_bclr = 32'd0;
            endcase
            step(r_ev, r_mwe, r_mwd, r_bclr, r_req, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
